// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake bundle for pipe_stage_reg
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master is the surrounding pipeline (upstream producer and downstream consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline register with valid/ready, flush, optional skid entry
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SKID        = 1,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  pipe_stage_reg_if.slave      bus,
  output logic [1:0]           o_occupancy,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_main;
  logic [WIDTH-1:0]      r_skid;
  logic [WIDTH-1:0]      w_main_nxt;
  logic [WIDTH-1:0]      w_skid_nxt;
  logic                  r_in_ready;
  logic [CNT_WIDTH-1:0]  r_stall;
  logic                  w_out_valid;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_consume;

  assign w_out_valid = (r_state != ST_EMPTY);
  // With a skid entry in_ready comes straight from a flop; without it, it looks through out_ready
  assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_consume   = w_out_valid && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VALUE;
      w_skid_nxt  = RESET_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_HALF;
            w_main_nxt  = bus.in_data;
          end
        end
        ST_HALF: begin
          if (w_accept && w_consume) begin
            w_main_nxt = bus.in_data;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = bus.in_data;
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RESET_VALUE;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt = ST_HALF;
            w_main_nxt  = r_skid;
            w_skid_nxt  = RESET_VALUE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = RESET_VALUE;
          w_skid_nxt  = RESET_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= RESET_VALUE;
      r_skid     <= RESET_VALUE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall != {CNT_WIDTH{1'b1}})) begin
      r_stall <= r_stall + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    o_occupancy = 2'd0;
    case (r_state)
      ST_HALF: o_occupancy = 2'd1;
      ST_FULL: o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_out_valid ? r_main : RESET_VALUE;
  assign o_stall_cycles  = r_stall;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline register for the five-stage core: a drop-in replacement for the hard-wired IF/ID, ID/EX, EX/MEM and MEM/WB register groups. Adds a valid/ready handshake so a stage can stall, a flush input so branches and exceptions can squash in-flight work, and an optional skid entry so `in_ready` is a registered signal. Holds one payload word plus up to one skid word, and counts stall cycles for performance analysis.

## Interface
- `WIDTH`, 32: payload width in bits; the instantiating stage packs control and data fields into it.
- `RESET_VALUE`, 0: payload presented on `out_data` whenever `out_valid`=0 (bubble / NOP encoding).
- `SKID`, 1: 1 gives a two-entry buffer with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `CNT_WIDTH`, 16: width of the stall counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all held entries this cycle.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  register can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is a live entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  WIDTH  head payload; `RESET_VALUE` when `out_valid`=0.
- `occupancy`  out  2  live entries, 0..2 (max 1 when `SKID`=0).
- `stall_cycles`  out  CNT_WIDTH  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- Storage: main entry (drives `out_*`) and, when `SKID`=1, a skid entry. Each has a valid bit.
- States (`SKID`=1): EMPTY (0 entries), HALF (main only), FULL (main + skid).
  - EMPTY: accept -> HALF, payload to main.
  - HALF: accept and consume -> HALF, main replaced by input. Accept only -> FULL, input to skid. Consume only -> EMPTY. Neither -> HALF.
  - FULL: consume -> HALF, skid moves to main. No accept is possible because `in_ready`=0.
- `in_ready` (`SKID`=1) = skid entry empty; registered, with no combinational path from `out_ready`.
- `SKID`=0: one entry. `in_ready` = !`out_valid` || `out_ready`. Accept with simultaneous consume replaces the entry with no bubble.
- Flush:
  - Clears both valid bits and forces stored payloads to `RESET_VALUE`.
  - Overrides any accept in the same cycle; the offered word is dropped.
  - The consume handshake in the flush cycle still counts as delivered, since downstream already sampled it.
- `out_data` is `RESET_VALUE` whenever `out_valid`=0. Stale payloads are never exposed, so downstream sees zeroed control fields in bubbles.
- `stall_cycles`:
  - Increments by 1 each cycle `out_valid && !out_ready`.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - Cleared only by `rst`; unaffected by `flush`.
- Ordering is strictly FIFO, with no duplication or loss except via `flush`.

## Timing
- Reset values: `out_valid`=0, `out_data`=`RESET_VALUE`, `occupancy`=0, `stall_cycles`=0. `in_ready`=1 in the cycle after reset deasserts, and during reset for `SKID`=0.
- Latency: a word accepted at edge N is visible on `out_data`/`out_valid` after edge N.
- Throughput: 1 word/cycle with `out_ready` held high, for both `SKID` values.
- `SKID`=1 full recovery: `out_ready` rising at edge N drains skid into main at N, and `in_ready` returns to 1 after N.
- Reset mid-operation (any state, including FULL) discards all entries on that edge. `rst` has priority over `flush` and handshakes.
- `flush` and `rst` are sampled at the edge only; no combinational effect on `in_ready`.

## Test plan
- Streaming, `SKID`=1, `out_ready`=1: feed 0x11..0x18 on consecutive cycles -> outputs 0x11..0x18 one cycle later, back-to-back, `occupancy`=1, `stall_cycles`=0.
- Backpressure: hold `out_ready`=0 and offer 0xA, 0xB, 0xC -> 0xA on output, 0xB in skid, `in_ready`=0, 0xC held upstream, `occupancy`=2. Release -> 0xA, 0xB, 0xC in order, and `stall_cycles` equals the stalled cycle count.
- Flush while FULL with `in_valid`=1 (0xD) -> next cycle `out_valid`=0, `out_data`=`RESET_VALUE`, `occupancy`=0. 0xD never appears.
- `SKID`=0, `out_ready` toggling 1,0,1,0: `in_ready` tracks `out_ready` combinationally while full -> no loss, no duplication, no bubble on simultaneous accept/consume.
- `CNT_WIDTH`=3, stall for 10 cycles -> `stall_cycles` stops at 7. A following flush leaves it at 7; `rst` clears it to 0.
- Assert `rst` while FULL with `flush`=1 and `in_valid`=1 -> all outputs at reset values next cycle, and no pre-reset word appears afterwards.
